// File: rtl/run_controller.sv
// Run sequencer: sequences core reset/enable/pause, counts run cycles and collects per-hart results.
// Optional feature: define RUN_CTRL_FAIL_FAST_EN to end the run on the first fail report (reason 3).
module run_controller #(
  parameter int DATA_W          = 32,
  parameter int NUM_HARTS       = 1,
  parameter int RST_HOLD_CYCLES = 10,
  parameter int CNT_W           = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    ctrl_i,
  input  logic [CNT_W-1:0]              timeout_i,
  input  logic [DATA_W-1:0]             success_code_i,
  input  logic [NUM_HARTS-1:0]          done_valid_i,
  input  logic [NUM_HARTS*DATA_W-1:0]   done_value_i,
  output logic                          core_reset_o,
  output logic                          core_enable_o,
  output logic [CNT_W-1:0]              cycle_count_o,
  output logic [NUM_HARTS-1:0]          pass_mask_o,
  output logic [NUM_HARTS-1:0]          fail_mask_o,
  output logic                          stop_o,
  output logic [1:0]                    done_reason_o,
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    ARMED    = 3'd2,
    RUN      = 3'd3,
    PAUSE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  state_t                state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [CNT_W-1:0]      timeout_q;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_W-1:0]     code_q;
  logic [NUM_HARTS-1:0]  hit;
  logic [NUM_HARTS-1:0]  fresh;
  logic [NUM_HARTS-1:0]  pass_d;
  logic [NUM_HARTS-1:0]  fail_d;
  logic                  all_in;
  logic                  timeout_hit;
  logic                  fail_stop;
  logic                  finish;
  logic [1:0]            finish_reason;

  assign state_o = state;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hit = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hit[h] = (done_value_i[h*DATA_W +: DATA_W] == code_q);
    end
  end

  // Only a hart's first report counts; later strobes from a decided hart are masked off.
  assign fresh       = done_valid_i & ~(pass_mask_o | fail_mask_o);
  assign pass_d      = pass_mask_o | (fresh & hit);
  assign fail_d      = fail_mask_o | (fresh & ~hit);
  assign all_in      = &(pass_d | fail_d);
  assign cnt_inc     = (&cycle_count_o) ? cycle_count_o : cycle_count_o + 1'b1;
  assign timeout_hit = (timeout_q != '0) && (cnt_inc == timeout_q);

`ifdef RUN_CTRL_FAIL_FAST_EN
  assign fail_stop = |(fresh & ~hit);
`else
  assign fail_stop = 1'b0;
`endif

  // Completion beats timeout when both land on the same edge.
  always_comb begin
    finish        = fail_stop | all_in | ((state == RUN) & timeout_hit);
    finish_reason = 2'd2;
    if (fail_stop) begin
      finish_reason = 2'd3;
    end else if (all_in) begin
      finish_reason = 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      timeout_q     <= '0;
      code_q        <= '0;
      core_reset_o  <= 1'b1;
      core_enable_o <= 1'b0;
      cycle_count_o <= '0;
      pass_mask_o   <= '0;
      fail_mask_o   <= '0;
      stop_o        <= 1'b0;
      done_reason_o <= 2'd0;
    end else if (ctrl_i[1] && state != RST_HOLD) begin
      state         <= RST_HOLD;
      hold_cnt      <= '0;
      core_reset_o  <= 1'b1;
      core_enable_o <= 1'b0;
      cycle_count_o <= '0;
      pass_mask_o   <= '0;
      fail_mask_o   <= '0;
      stop_o        <= 1'b0;
      done_reason_o <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
        end
        RST_HOLD: begin
          if (ctrl_i[1]) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state        <= ARMED;
            core_reset_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ARMED: begin
          if (ctrl_i[0]) begin
            state         <= RUN;
            core_enable_o <= 1'b1;
            timeout_q     <= timeout_i;
            code_q        <= success_code_i;
          end
        end
        RUN, PAUSE: begin
          pass_mask_o <= pass_d;
          fail_mask_o <= fail_d;
          if (state == RUN) begin
            cycle_count_o <= cnt_inc;
          end
          if (finish) begin
            state         <= DONE;
            done_reason_o <= finish_reason;
            stop_o        <= 1'b1;
            core_enable_o <= 1'b0;
          end else if (state == RUN && !ctrl_i[0]) begin
            state         <= PAUSE;
            core_enable_o <= 1'b0;
          end else if (state == PAUSE && ctrl_i[0]) begin
            state         <= RUN;
            core_enable_o <= 1'b1;
          end
        end
        DONE: begin
          if (ctrl_i[2]) begin
            state        <= IDLE;
            stop_o       <= 1'b0;
            core_reset_o <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          core_reset_o <= 1'b1;
          stop_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
